// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle integer ALU with valid/ready handshake; iterative sll/srl
// unless ALU_EXEC_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q;
  logic               in_ready_q, out_valid_q, zero_q, ovf_q, ill_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, alu_ill, lt;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt   = $signed(op_a) < $signed(op_b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
  logic [WIDTH-1:0] shl, shr;
  assign shl = op_b << shamt;
  assign shr = op_b >> shamt;
`else
  // Shifts load op_b on accept; the SHIFT state walks it one bit per cycle.
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               is_shift;
  logic [WIDTH-1:0]   shift_nxt;
  logic [WIDTH-1:0]   shl, shr;
  assign shl       = op_b;
  assign shr       = op_b;
  assign is_shift  = alu_ctrl[3:1] == 3'b010;
  assign shift_nxt = dir_q ? res_q >> 1 : res_q << 1;
`endif
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = alu_ctrl[3];
    case (alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0011: alu_res = op_a ^ op_b;
      4'b0100: alu_res = shl;
      4'b0101: alu_res = shr;
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      cnt_q       <= '0;
      dir_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          res_q      <= alu_res;
          zero_q     <= alu_res == '0;
          ovf_q      <= alu_ovf;
          ill_q      <= alu_ill;
          in_ready_q <= 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
          if (is_shift && shamt != '0) begin
            cnt_q   <= shamt;
            dir_q   <= alu_ctrl[0];
            state_q <= SHIFT;
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
`else
          state_q     <= DONE;
          out_valid_q <= 1'b1;
`endif
        end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
        SHIFT: begin
          res_q  <= shift_nxt;
          zero_q <= shift_nxt == '0;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
`endif
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
endmodule
